// File: rtl/reg_fifo.sv
// reg_fifo: byte FIFO placed after the 8-bit register stage.
// Flip-flop storage, one write and one read per cycle, registered read data,
// count-based full/empty and sticky overflow/underflow error flags.
module reg_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     din,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_CNT  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [DEPTH_LOG2:0]   count_nxt_s;
  logic                  full_r;
  logic                  empty_r;
  logic [DATA_W-1:0]     dout_r;
  logic                  dout_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Accept decisions: a full FIFO rejects writes, an empty FIFO rejects reads.
  always_comb begin
    wr_acc_s = wr_en & ~full_r;
    rd_acc_s = rd_en & ~empty_r;
  end

  // Next occupancy; simultaneous accepted read and write leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array: written only on an accepted write, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and the full/empty flags registered from next count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_CNT);
      empty_r <= (count_nxt_s == '0);
    end
  end

  // Registered read port: dout holds its value unless a read is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        dout_r <= mem_r[rd_ptr_r];
      end else begin
        dout_r <= dout_r;
      end
      dout_valid_r <= rd_acc_s;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= overflow_r  | (wr_en & full_r);
      underflow_r <= underflow_r | (rd_en & empty_r);
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign count      = count_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule
